imem_arbiter: RTL
=================

# imem_arbiter

Single-port instruction-memory arbiter between the instruction fetch unit and the UART program loader. It time-shares one synchronous-read block RAM of 32-bit words (1-cycle read latency). It returns fetched instructions with a valid strobe and raises a stall that freezes the PC while a fetch is outstanding. A wait counter bounds fetch starvation while the loader streams a program image.

## Interface
- ADDR_W, 14, word-address width of the memory; byte address bits [ADDR_W+1:2] are used.
- MAX_WAIT, 4, consecutive loader grants tolerated while a fetch is pending (1..255).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- f_req  in  1  fetch request; held with f_addr until granted.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch granted this cycle (combinational).
- f_rvalid  out  1  f_rdata valid; one cycle after f_gnt.
- f_rdata  out  32  fetched instruction, registered hold.
- f_stall  out  1  fetch pending-but-ungranted or granted-awaiting-data.
- l_req  in  1  loader write request; held with l_addr/l_wdata until granted.
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write word.
- l_gnt  out  1  loader granted this cycle (combinational).
- l_err  out  1  one-cycle pulse: granted loader write was misaligned and dropped.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid cycle after a read enable.

## Operation
- Arbitration, per cycle: at most one grant.
  - Only one requester: it is granted.
  - Both requesting: loader wins unless wait_cnt == MAX_WAIT, then fetch wins.
- wait_cnt (8-bit):
  - increments on a cycle with f_req=1 and l_gnt=1;
  - clears on f_gnt, or on any cycle with f_req=0;
  - saturates at MAX_WAIT.
- Fetch grant: mem_en=1, mem_we=0, mem_addr=f_addr[ADDR_W+1:2]. f_addr[1:0] ignored; upper bits ignored (addresses wrap modulo 2^ADDR_W words).
- Loader grant:
  - aligned (l_addr[1:0]==0): mem_en=1, mem_we=1, mem_addr=l_addr[ADDR_W+1:2], mem_wdata=l_wdata.
  - misaligned: mem_en=0, no write; l_err=1 next cycle.
- Read tracking: register rd_pend set on f_gnt, cleared otherwise. When rd_pend=1: f_rvalid=1 and f_rdata<=mem_rdata; otherwise f_rdata holds.
- f_stall = (f_req & ~f_gnt) | (f_gnt) — PC must not advance until the f_rvalid cycle.
- Back-to-back fetches allowed: f_gnt in cycle k+1 with f_rvalid in the same cycle for the k read.
- Write then read of the same address in consecutive cycles returns the newly written word.
- No grant: mem_en=0, mem_we=0; mem_addr/mem_wdata don't-care (drive 0).

## Timing
- Reset: f_rvalid=0, f_rdata=0, l_err=0, wait_cnt=0, rd_pend=0.
  - Grants are combinational on inputs, so with rst=1 force f_gnt=l_gnt=mem_en=mem_we=0 and f_stall=0.
- Reset mid-read: the read granted in the cycle before rst rises is discarded; no f_rvalid in the cycle after rst.
- Latency: fetch grant to f_rvalid = 1 cycle. Loader grant to memory write = same cycle (write edge at end of grant cycle).
- Worst-case fetch wait with a continuous loader stream: MAX_WAIT cycles, granted in cycle MAX_WAIT+1.
- l_err pulses exactly one cycle, the cycle after the misaligned grant.

## Test plan
- Reset then f_req=1, f_addr=0x8 with memory word[2]=0xDEADBEEF -> f_gnt in cycle 0, mem_addr=2; f_rvalid=1 with f_rdata=0xDEADBEEF in cycle 1; f_stall=1 in cycle 0 only.
- Loader writes 0x12345678 to 0x40 at cycle 0, fetch 0x40 at cycle 1 -> l_gnt, mem_we=1, mem_addr=0x10 at cycle 0; f_rvalid with f_rdata=0x12345678 at cycle 2.
- l_req held high continuously, f_req=1 from cycle 0, MAX_WAIT=4 -> l_gnt cycles 0-3, f_gnt cycle 4, wait_cnt back to 0; l_gnt resumes cycle 5.
- Loader address 0x42 -> l_gnt=1, mem_en=0, l_err=1 for exactly one cycle next; memory unchanged.
- Fetches at 0x0, 0x4, 0x8 on consecutive cycles -> f_gnt on each, f_rvalid on three consecutive cycles with words 0, 1, 2 in order.
- Fetch granted at cycle 0, rst=1 in cycle 1 -> f_rvalid=0, f_rdata=0, no grants while rst=1; normal fetch completes after release.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Bus bundle shared by the instruction fetch unit, the UART loader, the
// instruction-memory arbiter and the single-port block RAM behind it.
interface imem_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [31:0]       f_rdata;
  logic              f_stall;
  logic              l_req;
  logic [31:0]       l_addr;
  logic [31:0]       l_wdata;
  logic              l_gnt;
  logic              l_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, f_stall, l_gnt, l_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_addr, l_wdata,
    input  f_gnt, f_rvalid, f_rdata, f_stall, l_gnt, l_err
  );

  modport mem (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port instruction-memory arbiter: fetch unit vs. UART program loader,
// with a bounded-starvation wait counter and a 1-cycle read-return path.
module imem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  imem_arbiter_if.slave bus
);
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic              fetch_win;
  logic              f_gnt;
  logic              l_gnt;
  logic              l_aligned;
  logic              l_write;
  logic [7:0]        wait_cnt;
  logic              rd_pend_p1;
  logic              l_err_p1;
  logic [31:0]       rdata_hold_p1;
  logic              unused_addr_bits;

  // Address bits outside the word index are intentionally ignored.
  assign unused_addr_bits = ^{bus.f_addr[31:ADDR_W+2], bus.f_addr[1:0],
                              bus.l_addr[31:ADDR_W+2]};

  // Fetch wins only when the loader is idle or the fetch has waited long enough.
  assign fetch_win = bus.f_req & (~bus.l_req | (wait_cnt == MAX_WAIT_C));
  assign f_gnt     = ~rst & fetch_win;
  assign l_gnt     = ~rst & bus.l_req & ~fetch_win;
  assign l_aligned = (bus.l_addr[1:0] == 2'b00);
  assign l_write   = l_gnt & l_aligned;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (f_gnt) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.f_addr[ADDR_W+1:2];
    end else if (l_write) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = bus.l_addr[ADDR_W+1:2];
      bus.mem_wdata = bus.l_wdata;
    end
  end

  assign bus.f_gnt   = f_gnt;
  assign bus.l_gnt   = l_gnt;
  assign bus.f_stall = ~rst & ((bus.f_req & ~f_gnt) | f_gnt);

  // ---- stage p0 -> p1: grant bookkeeping registered at the grant edge ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= 8'd0;
      rd_pend_p1 <= 1'b0;
      l_err_p1   <= 1'b0;
    end else begin
      rd_pend_p1 <= f_gnt;
      l_err_p1   <= l_gnt & ~l_aligned;
      if (f_gnt || !bus.f_req) begin
        wait_cnt <= 8'd0;
      end else if (l_gnt && (wait_cnt < MAX_WAIT_C)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // ---- stage p1: read data arrives from the RAM and is captured for hold ----
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_hold_p1 <= '0;
    end else if (rd_pend_p1) begin
      rdata_hold_p1 <= bus.mem_rdata;
    end
  end

  // A read in flight when reset arrives is dropped on the output side too.
  assign bus.f_rvalid = ~rst & rd_pend_p1;
  assign bus.f_rdata  = rst        ? 32'd0 :
                        rd_pend_p1 ? bus.mem_rdata : rdata_hold_p1;
  assign bus.l_err    = l_err_p1;
endmodule
